sync_fifo: RTL

Parametrised single-clock FIFO that succeeds the one-entry CDC FIFO for same-domain buffering between AXI-side pipeline stages (request queues, response buffers) inside one clock domain. It provides configurable width and depth, an occupancy count, programmable almost-full and almost-empty flags, and a selectable first-word-fall-through (FWFT) or registered read mode. It also provides synchronous flush and sticky overflow/underflow error flags for debug.

---
 rtl/fifo_pkg.sv | 23 ++
 rtl/sfifo_mem.sv | 28 ++
 rtl/sync_fifo.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared helpers and types for the single-clock FIFO.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package fifo_pkg;

  // Pointer width; a one-entry FIFO still needs a 1-bit address.
  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Occupancy width: one extra bit so that count == DEPTH is representable.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_status_t;

endpackage

// File: rtl/sfifo_mem.sv
// sfifo_mem: DEPTH x DATA_WIDTH storage array, one write port, one async read port.
// Latency: write lands on posedge; read is combinational from raddr.
// Backpressure: none; the caller gates we.
// Ports: clk; we/waddr/wdata write port; raddr/rdata read port. Contents are not reset.
module sfifo_mem #(
  parameter int DATA_WIDTH = 51,
  parameter int DEPTH      = 4,
  parameter int ADDR       = 2
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR-1:0]       waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR-1:0]       raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy, almost flags, sticky errors, flush.
// Latency: FWFT=1 head visible the cycle after the push; FWFT=0 rdata valid one cycle after pop.
// Backpressure: push at full is dropped (overflow) unless a pop is accepted the same cycle.
// Ports: clk/rstn; flush; push/wdata write side; pop/rdata/rvalid read side;
//        full/empty/almost_full/almost_empty/count status; clr_err/overflow/underflow debug.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 51,
  parameter int DEPTH      = 4,
  parameter int AF_LEVEL   = DEPTH - 1,
  parameter int AE_LEVEL   = 1,
  parameter int FWFT       = 1
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     flush,
  input  logic                     push,
  input  logic [DATA_WIDTH-1:0]    wdata,
  input  logic                     pop,
  output logic [DATA_WIDTH-1:0]    rdata,
  output logic                     rvalid,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  input  logic                     clr_err,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int ADDR = addr_w(DEPTH);
  localparam int CW   = cnt_w(DEPTH);

  logic [ADDR-1:0]       wptr;
  logic [ADDR-1:0]       rptr;
  logic [CW-1:0]         cnt;
  logic [DATA_WIDTH-1:0] mem_rdata;
  fifo_status_t          st;
  logic                  push_acc;
  logic                  pop_acc;

  // Every flag is a pure decode of the count register, so all status
  // outputs move only on a clock edge or on reset.
  always_comb begin
    st              = '0;
    st.full         = (cnt == CW'(DEPTH));
    st.empty        = (cnt == '0);
    st.almost_full  = (int'(cnt) >= AF_LEVEL);
    st.almost_empty = (int'(cnt) <= AE_LEVEL);
  end

  assign full         = st.full;
  assign empty        = st.empty;
  assign almost_full  = st.almost_full;
  assign almost_empty = st.almost_empty;
  assign count        = cnt;

  // A pop frees a slot in the same cycle, so a push at full still goes in
  // when paired with an accepted pop. A pop at empty is never accepted, even
  // alongside a push: the new word is not yet readable.
  assign pop_acc  = pop & ~st.empty;
  assign push_acc = push & (~st.full | pop_acc);

  sfifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR       (ADDR)
  ) u_mem (
    .clk   (clk),
    .we    (push_acc & ~flush),
    .waddr (wptr),
    .wdata (wdata),
    .raddr (rptr),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push_acc) begin
        wptr <= wptr + 1'b1;
      end
      if (pop_acc) begin
        rptr <= rptr + 1'b1;
      end
      case ({push_acc, pop_acc})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Sticky error flags: a fresh error in the same cycle as clr_err wins.
  // Errors reflect the attempted operation and are not masked by flush.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push & ~push_acc) begin
        overflow <= 1'b1;
      end else if (clr_err) begin
        overflow <= 1'b0;
      end
      if (pop & st.empty) begin
        underflow <= 1'b1;
      end else if (clr_err) begin
        underflow <= 1'b0;
      end
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head entry is always presented; valid whenever anything is stored.
      assign rdata  = mem_rdata;
      assign rvalid = ~st.empty;
    end else begin : g_reg
      logic [DATA_WIDTH-1:0] rdata_q;
      logic                  rvalid_q;

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          rdata_q  <= '0;
          rvalid_q <= 1'b0;
        end else if (flush) begin
          rvalid_q <= 1'b0;
        end else if (pop_acc) begin
          rdata_q  <= mem_rdata;
          rvalid_q <= 1'b1;
        end else begin
          rvalid_q <= 1'b0;
        end
      end

      assign rdata  = rdata_q;
      assign rvalid = rvalid_q;
    end
  endgenerate

endmodule
